// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared bus widths, load-size encodings and MEM-stage state type
//   ES_TO_MS_BUS_WD  {ld_size[1:0],ld_uns,res_from_mem,gr_we,dest[4:0],alu_result,pc}
//   MS_TO_WS_BUS_WD  {gr_we,dest[4:0],final_result,pc}
//   MS_FWD_BUS_WD    {fwd_ready,final_result,dest}
package mem_stage_lsu_pkg;

    localparam int DATA_W_DEF = 32;

    function automatic int es_to_ms_bus_wd(input int dw);
        return dw * 2 + 10;
    endfunction

    function automatic int ms_to_ws_bus_wd(input int dw);
        return dw * 2 + 6;
    endfunction

    function automatic int ms_fwd_bus_wd(input int dw);
        return dw + 6;
    endfunction

    localparam int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(DATA_W_DEF);
    localparam int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(DATA_W_DEF);
    localparam int MS_FWD_BUS_WD   = ms_fwd_bus_wd(DATA_W_DEF);

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_DONE  = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align: picks the addressed lane out of a read word and sign/zero-extends it
//   rdata    in   DATA_W  raw response data
//   offset   in   OFF_W   byte offset of the access within the word
//   ld_size  in   2       LD_B / LD_H / LD_W / LD_D
//   ld_uns   in   1       1 = zero-extend, 0 = sign-extend
//   result   out  DATA_W  right-justified, extended lane
module load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = (DATA_W == 64) ? 3 : 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        ld_size,
    input  logic              ld_uns,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] M_B = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] M_H = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] M_W = DATA_W'(32'hFFFF_FFFF);

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic              sgn;

    // Accesses are naturally aligned, so shifting by the byte offset right-justifies
    // the lane; bits above it are then replaced by the extension.
    always_comb begin
        lane   = rdata >> {offset, 3'b000};
        mask   = (ld_size == LD_B) ? M_B :
                 (ld_size == LD_H) ? M_H :
                 (ld_size == LD_W) ? M_W : {DATA_W{1'b1}};
        sgn    = (ld_size == LD_B) ? lane[7]  :
                 (ld_size == LD_H) ? lane[15] :
                 (ld_size == LD_W) ? lane[31] : 1'b0;
        result = (lane & mask) | ({DATA_W{sgn & ~ld_uns}} & ~mask);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with variable-latency load responses and orphan-response drop
//   clk, resetn          clock; asynchronous active-low reset
//   flush                WB exception/ertn, kills the stage contents
//   ws_allowin           WB can accept            ms_allowin      MS can accept from EX
//   es_to_ms_valid/bus   EX offer and payload     es_req_pending  EX holds an accepted, unpassed load
//   ms_to_ws_valid/bus   result to WB             ms_fwd_bus      {fwd_ready, final_result, dest}
//   data_sram_data_ok    one read response        data_sram_rdata response data
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int CANCEL_W = 2,
    localparam int ES_BUS_W = es_to_ms_bus_wd(DATA_W),
    localparam int MS_BUS_W = ms_to_ws_bus_wd(DATA_W),
    localparam int FWD_W    = ms_fwd_bus_wd(DATA_W)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                ws_allowin,
    output logic                ms_allowin,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic                es_req_pending,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    output logic [FWD_W-1:0]    ms_fwd_bus
);

    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;
    localparam int SUM_W = CANCEL_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CANCEL_W) - 1);

    ms_state_e state;
    ms_state_e state_next;

    logic [1:0]        es_ld_size;
    logic              es_ld_uns;
    logic              es_res_from_mem;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [DATA_W-1:0] es_alu_result;
    logic [DATA_W-1:0] es_pc;

    logic [1:0]        ld_size;
    logic              ld_uns;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rdata_buf;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] final_result;

    logic                ms_valid;
    logic                ms_ready_go;
    logic                accept;
    logic                resp_ok;
    logic                drop;
    logic [CANCEL_W-1:0] cancel_cnt;
    logic [SUM_W-1:0]    cnt_sum;

    assign {es_ld_size, es_ld_uns, es_res_from_mem, es_gr_we, es_dest, es_alu_result, es_pc} = es_to_ms_bus;

    assign accept  = ms_allowin && es_to_ms_valid && !flush;
    // Responses come back in order, so while orphans are owed every data_ok belongs to one of them.
    assign resp_ok = data_sram_data_ok && cancel_cnt == '0;
    assign drop    = data_sram_data_ok && cancel_cnt != '0;

    // On a flush, the killed load in MS (if its response is still owed) and any load
    // EX has already issued each leave one response in flight that must be discarded.
    assign cnt_sum = SUM_W'(cancel_cnt) - SUM_W'(drop)
                   + (flush ? SUM_W'(state == MS_WAIT && !resp_ok) + SUM_W'(es_req_pending) : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MS_EMPTY;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)                               state_next = MS_EMPTY;
        else if (accept)                         state_next = es_res_from_mem ? MS_WAIT : MS_DONE;
        else if (state == MS_WAIT && resp_ok)    state_next = MS_DONE;
        else if (state == MS_DONE && ws_allowin) state_next = MS_EMPTY;
    end

    always_comb begin
        ms_valid       = state != MS_EMPTY;
        ms_ready_go    = state == MS_DONE;
        ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cancel_cnt <= '0;
        else         cancel_cnt <= cnt_sum[CANCEL_W-1:0];
    end

    // Payload is cleared on reset so the forwarding bus reads all-zero out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {ld_size, ld_uns, res_from_mem, gr_we, dest, alu_result, pc} <= '0;
            rdata_buf <= '0;
        end else begin
            if (accept)
                {ld_size, ld_uns, res_from_mem, gr_we, dest, alu_result, pc} <= es_to_ms_bus;
            if (state == MS_WAIT && resp_ok)
                rdata_buf <= ld_data;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata   (data_sram_rdata),
        .offset  (alu_result[OFF_W-1:0]),
        .ld_size (ld_size),
        .ld_uns  (ld_uns),
        .result  (ld_data)
    );

    assign final_result = res_from_mem ? rdata_buf : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_fwd_bus   = {ms_ready_go, final_result, dest & {5{ms_valid}}};

    a_cancel_no_sat: assert property (@(posedge clk) disable iff (!resetn) cnt_sum <= CNT_MAX);
    a_no_stray_ok:   assert property (@(posedge clk) disable iff (!resetn)
                                      !(data_sram_data_ok && state != MS_WAIT && cancel_cnt == '0));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven and scenario checks of mem_stage_lsu with a WB-side scoreboard
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    localparam int DW   = 32;
    localparam int ESW  = DW * 2 + 10;
    localparam int MSW  = DW * 2 + 6;
    localparam int FWDW = DW + 6;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            flush = 1'b0;
    logic            ws_allowin = 1'b1;
    logic            ms_allowin;
    logic            es_to_ms_valid = 1'b0;
    logic [ESW-1:0]  es_to_ms_bus = '0;
    logic            es_req_pending = 1'b0;
    logic            ms_to_ws_valid;
    logic [MSW-1:0]  ms_to_ws_bus;
    logic            data_ok = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic [FWDW-1:0] ms_fwd_bus;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]  pc = 32'h1c00_0000;
    logic [MSW-1:0] sb[$];

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic        mem;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rd;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    mem_stage_lsu #(.DATA_W(DW), .CANCEL_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_req_pending    (es_req_pending),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // WB side: every transfer WB takes must match the oldest expected result.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got %0h expected no transfer", ms_to_ws_bus);
            end else begin
                chk("wb_bus", 128'(ms_to_ws_bus), 128'(sb.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input vec_t v, input bit push);
        int n;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {v.size, v.uns, v.mem, 1'b1, v.dest, v.alu, pc};
        n = 0;
        while (!ms_allowin && n < 50) begin
            step();
            n++;
        end
        if (!ms_allowin) chk("issue_timeout", 128'(ms_allowin), 128'(1));
        if (push) sb.push_back({1'b1, v.dest, v.exp, pc});
        step();
        es_to_ms_valid = 1'b0;
        pc = pc + 4;
    endtask

    // Holds the load in WAIT for lat cycles, then supplies its response.
    task automatic respond(input int lat, input logic [31:0] rd);
        for (int i = 0; i <= lat; i++) begin
            if (i == lat) begin
                data_ok = 1'b1;
                rdata   = rd;
            end
            @(negedge clk);
            chk("fwd_ready_wait", 128'(ms_fwd_bus[FWDW-1]), 128'(0));
            chk("allowin_wait", 128'(ms_allowin), 128'(0));
            step();
        end
        data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = '{LD_W, 1'b0, 1'b0, 5'd1,  32'h0000_1234, 32'h0,         0, 32'h0000_1234};
        vecs[1]  = '{LD_B, 1'b0, 1'b1, 5'd2,  32'h1000_0003, 32'h80FF_FF00, 3, 32'hFFFF_FF80};
        vecs[2]  = '{LD_B, 1'b1, 1'b1, 5'd3,  32'h1000_0003, 32'h80FF_FF00, 3, 32'h0000_0080};
        vecs[3]  = '{LD_H, 1'b0, 1'b1, 5'd4,  32'h1000_0002, 32'h80FF_FF00, 0, 32'hFFFF_80FF};
        vecs[4]  = '{LD_H, 1'b1, 1'b1, 5'd5,  32'h1000_0002, 32'h80FF_FF00, 1, 32'h0000_80FF};
        vecs[5]  = '{LD_W, 1'b0, 1'b1, 5'd6,  32'h1000_0000, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
        vecs[6]  = '{LD_B, 1'b0, 1'b1, 5'd7,  32'h1000_0000, 32'h1234_567F, 0, 32'h0000_007F};
        vecs[7]  = '{LD_H, 1'b0, 1'b1, 5'd8,  32'h1000_0000, 32'h0000_8001, 1, 32'hFFFF_8001};
        vecs[8]  = '{LD_B, 1'b1, 1'b1, 5'd9,  32'h1000_0001, 32'hAABB_CCDD, 0, 32'h0000_00CC};
        vecs[9]  = '{LD_B, 1'b0, 1'b1, 5'd10, 32'h1000_0002, 32'hAABB_CCDD, 2, 32'hFFFF_FFBB};
        vecs[10] = '{LD_W, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0,         0, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("rst_fwd", 128'(ms_fwd_bus), 128'(0));
        chk("rst_allowin", 128'(ms_allowin), 128'(1));
        chk("rst_cnt", 128'(dut.cancel_cnt), 128'(0));
        resetn = 1'b1;
        step();

        foreach (vecs[i]) begin
            v = vecs[i];
            issue(v, 1'b1);
            if (v.mem) respond(v.lat, v.rd);
            @(negedge clk);
            chk("vec_valid", 128'(ms_to_ws_valid), 128'(1));
            chk("vec_fwd_ready", 128'(ms_fwd_bus[FWDW-1]), 128'(1));
            chk("vec_fwd_result", 128'(ms_fwd_bus[FWDW-2:5]), 128'(v.exp));
            chk("vec_fwd_dest", 128'(ms_fwd_bus[4:0]), 128'(v.dest));
            step();
        end

        // Result arrives while WB stalls and must stay put.
        ws_allowin = 1'b0;
        issue(vecs[4], 1'b1);
        respond(1, 32'h80FF_FF00);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", 128'(ms_to_ws_valid), 128'(1));
            chk("stall_result", 128'(ms_to_ws_bus[2*DW-1:DW]), 128'(32'h0000_80FF));
            chk("stall_allowin", 128'(ms_allowin), 128'(0));
            step();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        step();

        // Flush in WAIT with a load pending in EX leaves two orphans ahead of the next load.
        issue(vecs[1], 1'b0);
        flush = 1'b1;
        es_req_pending = 1'b1;
        step();
        flush = 1'b0;
        es_req_pending = 1'b0;
        @(negedge clk);
        chk("flush_cnt2", 128'(dut.cancel_cnt), 128'(2));
        chk("flush_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("flush_allowin", 128'(ms_allowin), 128'(1));
        step();
        issue(vecs[5], 1'b1);
        data_ok = 1'b1;
        rdata   = 32'h0BAD_0001;
        step();
        rdata   = 32'h0BAD_0002;
        @(negedge clk);
        chk("orphan_cnt1", 128'(dut.cancel_cnt), 128'(1));
        chk("orphan_valid1", 128'(ms_to_ws_valid), 128'(0));
        step();
        data_ok = 1'b0;
        @(negedge clk);
        chk("orphan_cnt0", 128'(dut.cancel_cnt), 128'(0));
        chk("orphan_fwd0", 128'(ms_fwd_bus[FWDW-1]), 128'(0));
        step();
        respond(1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("orphan_done", 128'(ms_to_ws_valid), 128'(1));
        step();

        // Flush coincident with the current load's own response.
        issue(vecs[3], 1'b0);
        step();
        data_ok = 1'b1;
        rdata   = 32'h80FF_FF00;
        flush   = 1'b1;
        step();
        data_ok = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        chk("coflush_cnt", 128'(dut.cancel_cnt), 128'(0));
        chk("coflush_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("coflush_allowin", 128'(ms_allowin), 128'(1));
        step();
        @(negedge clk);
        chk("coflush_valid2", 128'(ms_to_ws_valid), 128'(0));
        step();

        // Reset while a load waits with one orphan owed.
        issue(vecs[6], 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("pre_rst_cnt1", 128'(dut.cancel_cnt), 128'(1));
        step();
        issue(vecs[7], 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("arst_fwd", 128'(ms_fwd_bus), 128'(0));
        chk("arst_bus", 128'(ms_to_ws_bus), 128'(0));
        chk("arst_cnt", 128'(dut.cancel_cnt), 128'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
        issue(vecs[0], 1'b1);
        @(negedge clk);
        chk("post_rst_valid", 128'(ms_to_ws_valid), 128'(1));
        step();
        step();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
